dmem_arbiter: RTL and testbench

Two-requester arbiter that sits directly downstream of the EX/MEM registers of Pipe_CPU_1 and Pipe_CPU_2. It serialises their loads and stores onto the single-port Data_Memory. It returns read data and a per-CPU stall to each pipeline, and keeps per-port stall counters and a sticky misalignment flag for debug.

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 52 +++++
 rtl/dmem_arbiter.sv | 104 ++++++++++
 tb/tb_dmem_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Purpose  : Shared constants for the dual-CPU data-memory arbiter.
//            Port indices follow the {CPU1, CPU2} packing of every paired bus,
//            so CPU1 is bit/slice 1 and CPU2 is bit/slice 0.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int P_CPU1     = 1;
    localparam int P_CPU2     = 0;
    localparam int NUM_PORTS  = 2;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_CNT_W  = 16;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin arbiter. The grant is combinational from the
//            current requests and the index of the last granted port.
// Ports    : clk_i        clock
//            rst_n        asynchronous active-low reset
//            i_req[1:0]   request per port ({CPU1, CPU2})
//            o_grant[1:0] one-hot grant (all zero when idle)
//            o_gnt_valid  any port granted this cycle
//            o_gnt_idx    index of the granted port (valid with o_gnt_valid)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant,
    output logic       o_gnt_valid,
    output logic       o_gnt_idx
);

    // Index of the most recently granted port. Resets to CPU2 so that CPU1
    // wins the first contention.
    logic r_last_grant;

    always_comb begin
        o_grant = 2'b00;
        unique case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            // Contention: serve whichever port did not go last.
            2'b11:   o_grant = (r_last_grant == 1'(P_CPU1)) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    assign o_gnt_valid = |i_req;
    assign o_gnt_idx   = o_grant[P_CPU1];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'(P_CPU2);
        end else if (o_gnt_valid) begin
            r_last_grant <= o_gnt_idx;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Serialises loads/stores from two pipelined CPUs onto a single-port
//            data memory with round-robin fairness, zero added read latency,
//            per-CPU stall, saturating stall counters and sticky misalignment
//            flags. Paired buses are packed {CPU1, CPU2}.
// Ports    : clk_i, rst_n                clock, async active-low reset
//            rd_i, wr_i, addr_i, wdata_i per-CPU memory requests
//            rdata_o, stall_o            per-CPU load data and stall
//            mem_addr_o, mem_wdata_o,
//            mem_rd_o, mem_wr_o,
//            mem_rdata_i                 single-port data memory interface
//            stall_cnt_o, misalign_o     debug counters / sticky flags
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic [1:0]            rd_i,
    input  logic [1:0]            wr_i,
    input  logic [2*ADDR_W-1:0]   addr_i,
    input  logic [2*DATA_W-1:0]   wdata_i,
    output logic [2*DATA_W-1:0]   rdata_o,
    output logic [1:0]            stall_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic [2*CNT_W-1:0]    stall_cnt_o,
    output logic [1:0]            misalign_o
);

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_gnt_valid;
    logic              w_gnt_idx;
    logic [ADDR_W-1:0] w_addr  [NUM_PORTS];
    logic [DATA_W-1:0] w_wdata [NUM_PORTS];

    // Requests are masked while reset is held so that the memory sees no
    // access and both pipelines are released from stall immediately.
    assign w_req = (rd_i | wr_i) & {2{rst_n}};

    rr_arbiter2 u_rr (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .i_req       (w_req),
        .o_grant     (w_grant),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    // Memory-side mux. A port with both rd and wr set performs a write.
    assign mem_addr_o  = w_gnt_valid ? w_addr[w_gnt_idx]  : '0;
    assign mem_wdata_o = w_gnt_valid ? w_wdata[w_gnt_idx] : '0;
    assign mem_wr_o    = w_gnt_valid & wr_i[w_gnt_idx];
    assign mem_rd_o    = w_gnt_valid & rd_i[w_gnt_idx] & ~wr_i[w_gnt_idx];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [DATA_W-1:0] r_hold;
        logic [CNT_W-1:0]  r_cnt;
        logic              r_misalign;

        assign w_addr[p]  = addr_i[p*ADDR_W +: ADDR_W];
        assign w_wdata[p] = wdata_i[p*DATA_W +: DATA_W];

        assign stall_o[p] = w_req[p] & ~w_grant[p];

        // Granted port sees memory data in the same cycle; otherwise the
        // slice shows the last value it loaded, stable across stalls.
        assign rdata_o[p*DATA_W +: DATA_W] = w_grant[p] ? mem_rdata_i : r_hold;

        assign stall_cnt_o[p*CNT_W +: CNT_W] = r_cnt;
        assign misalign_o[p]                 = r_misalign;

        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                r_hold     <= '0;
                r_cnt      <= '0;
                r_misalign <= 1'b0;
            end else begin
                if (w_grant[p] && rd_i[p]) begin
                    r_hold <= mem_rdata_i;
                end
                if (stall_o[p] && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_grant[p] && (w_addr[p][1:0] != 2'b00)) begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter with a small
//            word-addressed memory model on the memory side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    // Narrow counters keep the saturation run short.
    localparam int CNT_W  = 10;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam int SAT_CYCLES = 2 * (1 << CNT_W) + 10;

    logic                  clk_i;
    logic                  rst_n;
    logic [1:0]            rd_i;
    logic [1:0]            wr_i;
    logic [2*ADDR_W-1:0]   addr_i;
    logic [2*DATA_W-1:0]   wdata_i;
    logic [2*DATA_W-1:0]   rdata_o;
    logic [1:0]            stall_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic                  mem_rd_o;
    logic                  mem_wr_o;
    logic [DATA_W-1:0]     mem_rdata_i;
    logic [2*CNT_W-1:0]    stall_cnt_o;
    logic [1:0]            misalign_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] mem [16];

    dmem_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .rd_i        (rd_i),
        .wr_i        (wr_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rd_o    (mem_rd_o),
        .mem_wr_o    (mem_wr_o),
        .mem_rdata_i (mem_rdata_i),
        .stall_cnt_o (stall_cnt_o),
        .misalign_o  (misalign_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Data memory model: combinational read, write on posedge.
    assign mem_rdata_i = mem[mem_addr_o[5:2]];
    always @(posedge clk_i) begin
        if (mem_wr_o) mem[mem_addr_o[5:2]] <= mem_wdata_o;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Apply a request set at the falling edge; return 2 time units later,
    // well before the next rising edge.
    task automatic set_req(input logic [1:0] rd, input logic [1:0] wr,
                           input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] d1, input logic [31:0] d2);
        @(negedge clk_i);
        rd_i    = rd;
        wr_i    = wr;
        addr_i  = {a1, a2};
        wdata_i = {d1, d2};
        #2;
    endtask

    task automatic pulse_reset();
        @(negedge clk_i);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [1:0] prev_stall;
    logic [1:0] exp_stall;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst_n = 1'b0; rd_i = '0; wr_i = '0; addr_i = '0; wdata_i = '0;

        // Reset, idle
        #12;
        check("rst_stall",  64'(stall_o),     64'h0);
        check("rst_memwr",  64'(mem_wr_o),    64'h0);
        check("rst_cnt",    64'(stall_cnt_o), 64'h0);
        check("rst_rdata",  rdata_o,          64'h0);
        @(negedge clk_i);
        rst_n = 1'b1;

        // CPU1 writes 0x55 to addr 8, then CPU2 reads it back
        set_req(2'b10, 2'b10, 32'd8, 32'd0, 32'h55, 32'h0);
        check("w1_memwr",   64'(mem_wr_o),    64'h1);
        check("w1_addr",    64'(mem_addr_o),  64'd8);
        check("w1_wdata",   64'(mem_wdata_o), 64'h55);
        check("w1_stall",   64'(stall_o),     64'h0);
        set_req(2'b01, 2'b00, 32'd0, 32'd8, 32'h0, 32'h0);
        check("r2_rdata",   64'(rdata_o[31:0]), 64'h55);
        check("r2_stall",   64'(stall_o),     64'h0);
        check("r2_memrd",   64'(mem_rd_o),    64'h1);

        // Simultaneous writes after reset: CPU1 first, then CPU2
        set_req(2'b00, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0);
        pulse_reset();
        set_req(2'b11, 2'b11, 32'd4, 32'd12, 32'd7, 32'd9);
        check("ww_stall0",  64'(stall_o),     64'h1);
        check("ww_addr0",   64'(mem_addr_o),  64'd4);
        set_req(2'b01, 2'b01, 32'd0, 32'd12, 32'd0, 32'd9);
        check("ww_stall1",  64'(stall_o),     64'h0);
        check("ww_addr1",   64'(mem_addr_o),  64'd12);
        check("ww_wdata1",  64'(mem_wdata_o), 64'd9);
        set_req(2'b00, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0);
        check("ww_mem4",    64'(mem[1]),      64'd7);
        check("ww_mem12",   64'(mem[3]),      64'd9);
        check("ww_cnt2",    64'(stall_cnt_o[CNT_W-1:0]),       64'd1);
        check("ww_cnt1",    64'(stall_cnt_o[2*CNT_W-1:CNT_W]), 64'd0);

        // Continuous reads from both: grants alternate, CPU1 first
        prev_stall = 2'b00;
        for (int k = 0; k < 10; k++) begin
            set_req(2'b11, 2'b00, 32'd4, 32'd12, 32'h0, 32'h0);
            exp_stall = (k % 2 == 0) ? 2'b01 : 2'b10;
            check($sformatf("rr_stall%0d", k), 64'(stall_o), 64'(exp_stall));
            check($sformatf("rr_nodbl%0d", k), 64'(stall_o & prev_stall), 64'h0);
            if (k % 2 == 0) check($sformatf("rr_rd1_%0d", k), 64'(rdata_o[63:32]), 64'd7);
            else            check($sformatf("rr_rd2_%0d", k), 64'(rdata_o[31:0]),  64'd9);
            prev_stall = stall_o;
        end
        set_req(2'b00, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0);
        check("rr_hold",    rdata_o,          {32'd7, 32'd9});
        check("rr_cnt2",    64'(stall_cnt_o[CNT_W-1:0]),       64'd6);
        check("rr_cnt1",    64'(stall_cnt_o[2*CNT_W-1:CNT_W]), 64'd5);

        // Misaligned CPU2 read at 6: sticky until reset
        set_req(2'b01, 2'b00, 32'd0, 32'd6, 32'h0, 32'h0);
        check("mis_addr",   64'(mem_addr_o),  64'd6);
        set_req(2'b10, 2'b10, 32'd0, 32'd0, 32'd1, 32'h0);
        check("mis_set",    64'(misalign_o),  64'h1);
        set_req(2'b01, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0);
        check("mis_sticky", 64'(misalign_o),  64'h1);
        set_req(2'b00, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0);
        pulse_reset();
        #1;
        check("mis_clr",    64'(misalign_o),  64'h0);

        // Long contention: both counters saturate, then async reset mid-stall
        set_req(2'b11, 2'b00, 32'd4, 32'd12, 32'h0, 32'h0);
        repeat (SAT_CYCLES) @(posedge clk_i);
        #2;
        check("sat_cnt2",   64'(stall_cnt_o[CNT_W-1:0]),       64'(c_cnt_max));
        check("sat_cnt1",   64'(stall_cnt_o[2*CNT_W-1:CNT_W]), 64'(c_cnt_max));
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_stall", 64'(stall_o),     64'h0);
        check("arst_cnt",   64'(stall_cnt_o), 64'h0);
        check("arst_memrd", 64'(mem_rd_o),    64'h0);
        @(negedge clk_i);
        rst_n = 1'b1;
        rd_i  = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
